// File: rtl/sound_pkg.sv
// Shared constants and types for the sound feeder slice.
package sound_pkg;

   localparam int SAMPLE_W         = 8;
   localparam int SLOTS            = 4;
   localparam int WORD_W           = SAMPLE_W * SLOTS;
   localparam int FRAME_CYCLES_DEF = 1024;

   // Four midscale (silent) samples.
   localparam logic [WORD_W-1:0] MIDSCALE_WORD = 32'h80808080;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } feeder_state_t;

endpackage : sound_pkg

// File: rtl/sound_byte_fifo.sv
// Byte FIFO with a single-byte push port and a four-byte pop port.
// The oldest byte appears in the top byte of pop_data. A pop only takes
// effect when at least four bytes were held before this cycle's push, so a
// byte written this cycle is never part of the word popped this cycle.
module sound_byte_fifo
   import sound_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [SAMPLE_W-1:0]      push_data,
   output logic                     push_ready,
   input  logic                     pop,
   output logic [WORD_W-1:0]        pop_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] SLOT_LVL = CNT_W'(SLOTS);

   logic [SAMPLE_W-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_reg;
   logic [PTR_W-1:0]    rd_ptr_reg;
   logic [CNT_W-1:0]    count_reg;
   logic [CNT_W-1:0]    count_next;
   logic                push_ok;
   logic                pop_ok;

   assign push_ready = (count_reg < FULL_LVL);
   assign push_ok    = push && push_ready;
   assign pop_ok     = pop && (count_reg >= SLOT_LVL);
   assign count      = count_reg;

   // Gather the four oldest bytes; pointers wrap naturally at DEPTH.
   generate
      for (genvar gi = 0; gi < SLOTS; gi++) begin : g_rd
         logic [PTR_W-1:0] rd_idx;
         assign rd_idx = rd_ptr_reg + PTR_W'(gi);
         assign pop_data[(SLOTS-1-gi)*SAMPLE_W +: SAMPLE_W] = mem_reg[rd_idx];
      end
   endgenerate

   // Byte count after this cycle's push and pop.
   always_comb begin
      count_next = count_reg;
      if (push_ok) count_next = count_next + CNT_W'(1);
      if (pop_ok)  count_next = count_next - SLOT_LVL;
   end

   // Storage array; contents need no reset since the count gates reads.
   always_ff @(posedge clk) begin
      if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
   end

   // Pointer and count bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(SLOTS);
         count_reg <= count_next;
      end
   end

endmodule : sound_byte_fifo

// File: rtl/sound_feeder.sv
// Sound feeder: buffers 8-bit samples and hands the PWM player one packed
// 4-sample word per frame, phase-locked to the player's frame counter.
// Optional macro SOUND_FEEDER_REPEAT_EN: on underrun, repeat the previous
// word instead of loading midscale silence.
module sound_feeder
   import sound_pkg::*;
#(
   parameter int DEPTH        = 64,
   parameter int PREFILL      = 16,
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [SAMPLE_W-1:0]      s_data,
   input  logic                     underrun_clr,
   output logic [WORD_W-1:0]        data_o,
   output logic                     aud_en_o,
   output logic                     frame_start_o,
   output logic                     underrun_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam int FC_W  = $clog2(FRAME_CYCLES);
   localparam logic [FC_W-1:0]  FC_LAST     = FC_W'(FRAME_CYCLES - 1);
   localparam logic [LVL_W-1:0] PREFILL_LVL = LVL_W'(PREFILL);
   localparam logic [LVL_W-1:0] SLOT_LVL    = LVL_W'(SLOTS);

   feeder_state_t     state_reg;
   logic [FC_W-1:0]   frame_cnt_reg;
   logic [WORD_W-1:0] data_reg;
   logic              aud_en_reg;
   logic              frame_start_reg;
   logic              underrun_reg;

   logic [LVL_W-1:0]  level;
   logic [WORD_W-1:0] pop_word;
   logic              start_ok;
   logic              boundary;
   logic              have_word;
   logic              pop;

   // Decisions use the registered count, i.e. the level before this cycle's push.
   assign have_word = (level >= SLOT_LVL);
   assign start_ok  = (state_reg == IDLE) && enable && (level >= PREFILL_LVL);
   assign boundary  = (state_reg == PLAY) && (frame_cnt_reg == FC_LAST);
   assign pop       = start_ok || (enable && boundary && have_word);

   sound_byte_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (s_valid),
      .push_data  (s_data),
      .push_ready (s_ready),
      .pop        (pop),
      .pop_data   (pop_word),
      .count      (level)
   );

   assign data_o        = data_reg;
   assign aud_en_o      = aud_en_reg;
   assign frame_start_o = frame_start_reg;
   assign underrun_o    = underrun_reg;
   assign level_o       = level;

   // Playback FSM: start on prefill, reload a word every frame, stop on enable drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         frame_cnt_reg   <= '0;
         data_reg        <= MIDSCALE_WORD;
         aud_en_reg      <= 1'b0;
         frame_start_reg <= 1'b0;
         underrun_reg    <= 1'b0;
      end else begin
         frame_start_reg <= 1'b0;
         // A set later in this block overrides the clear.
         if (underrun_clr) underrun_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               frame_cnt_reg <= '0;
               aud_en_reg    <= 1'b0;
               if (start_ok) begin
                  // Player counter is at 0 on this edge, so both run in lockstep.
                  data_reg        <= pop_word;
                  aud_en_reg      <= 1'b1;
                  frame_start_reg <= 1'b1;
                  state_reg       <= PLAY;
               end
            end
            PLAY: begin
               if (!enable) begin
                  aud_en_reg    <= 1'b0;
                  frame_cnt_reg <= '0;
                  data_reg      <= MIDSCALE_WORD;
                  state_reg     <= IDLE;
               end else begin
                  frame_cnt_reg <= frame_cnt_reg + FC_W'(1);
                  if (boundary) begin
                     frame_cnt_reg   <= '0;
                     frame_start_reg <= 1'b1;
                     if (have_word) begin
                        data_reg <= pop_word;
                     end else begin
                        // Keep aud_en high so the player stays aligned.
`ifdef SOUND_FEEDER_REPEAT_EN
                        data_reg <= data_reg;
`else
                        data_reg <= MIDSCALE_WORD;
`endif
                        underrun_reg <= 1'b1;
                     end
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule : sound_feeder

// File: tb/tb_sound_feeder.sv
// Directed self-checking bench for sound_feeder (DEPTH 64, PREFILL 16, 1024-cycle frames).
module tb_sound_feeder;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        underrun_clr;
   logic [31:0] data_o;
   logic        aud_en_o;
   logic        frame_start_o;
   logic        underrun_o;
   logic [6:0]  level_o;

   int checks   = 0;
   int failures = 0;
   int acc      = 0;

   sound_feeder #(
      .DEPTH(64),
      .PREFILL(16),
      .FRAME_CYCLES(1024)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .underrun_clr  (underrun_clr),
      .data_o        (data_o),
      .aud_en_o      (aud_en_o),
      .frame_start_o (frame_start_o),
      .underrun_o    (underrun_o),
      .level_o       (level_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock while holding s_valid; advances the byte stream on acceptance.
   task automatic stream_tick();
      logic taken;
      taken = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (taken) begin
         acc++;
         s_data = acc[7:0];
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = 8'h00; underrun_clr = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      checks++; if (data_o !== 32'h80808080) begin failures++; $display("FAIL reset_data got=%h exp=80808080", data_o); end
      checks++; if (aud_en_o !== 1'b0) begin failures++; $display("FAIL reset_aud_en got=%b exp=0", aud_en_o); end
      checks++; if (frame_start_o !== 1'b0) begin failures++; $display("FAIL reset_frame_start got=%b exp=0", frame_start_o); end
      checks++; if (underrun_o !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun_o); end
      checks++; if (level_o !== 7'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level_o); end
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
      $display("reset: data=%h aud_en=%b level=%0d", data_o, aud_en_o, level_o);
   endtask

   task automatic test_playback();
      logic [31:0] words  [3];
      logic [6:0]  levels [3];
      logic [31:0] prev;
      logic [31:0] ur_word;
      int bad;
      words[0] = 32'h05060708; words[1] = 32'h090A0B0C; words[2] = 32'h0D0E0F10;
      levels[0] = 7'd8; levels[1] = 7'd4; levels[2] = 7'd0;
      enable = 1'b1;
      s_valid = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         s_data = 8'(i);
         tick();
      end
      s_valid = 1'b0;
      checks++; if (aud_en_o !== 1'b0) begin failures++; $display("FAIL prefill_aud_en_early got=%b exp=0", aud_en_o); end
      checks++; if (level_o !== 7'd16) begin failures++; $display("FAIL prefill_level got=%0d exp=16", level_o); end
      tick();
      checks++; if (aud_en_o !== 1'b1) begin failures++; $display("FAIL start_aud_en got=%b exp=1", aud_en_o); end
      checks++; if (frame_start_o !== 1'b1) begin failures++; $display("FAIL start_frame_start got=%b exp=1", frame_start_o); end
      checks++; if (data_o !== 32'h01020304) begin failures++; $display("FAIL start_word got=%h exp=01020304", data_o); end
      checks++; if (level_o !== 7'd12) begin failures++; $display("FAIL start_level got=%0d exp=12", level_o); end
      $display("load: data=%h level=%0d", data_o, level_o);
      prev = 32'h01020304;
      for (int k = 0; k < 3; k++) begin
         bad = 0;
         for (int c = 0; c < 1023; c++) begin
            tick();
            if (frame_start_o !== 1'b0 || data_o !== prev || aud_en_o !== 1'b1 || underrun_o !== 1'b0) bad++;
         end
         checks++; if (bad != 0) begin failures++; $display("FAIL frame_quiet_%0d got=%0d bad cycles exp=0", k, bad); end
         tick();
         checks++; if (frame_start_o !== 1'b1) begin failures++; $display("FAIL frame_pulse_%0d got=%b exp=1", k, frame_start_o); end
         checks++; if (data_o !== words[k]) begin failures++; $display("FAIL frame_word_%0d got=%h exp=%h", k, data_o, words[k]); end
         checks++; if (level_o !== levels[k]) begin failures++; $display("FAIL frame_level_%0d got=%0d exp=%0d", k, level_o, levels[k]); end
         $display("load: data=%h level=%0d", data_o, level_o);
         prev = words[k];
      end
`ifdef SOUND_FEEDER_REPEAT_EN
      ur_word = 32'h0D0E0F10;
`else
      ur_word = 32'h80808080;
`endif
      repeat (1023) tick();
      checks++; if (underrun_o !== 1'b0) begin failures++; $display("FAIL underrun_early got=%b exp=0", underrun_o); end
      tick();
      checks++; if (data_o !== ur_word) begin failures++; $display("FAIL underrun_word got=%h exp=%h", data_o, ur_word); end
      checks++; if (underrun_o !== 1'b1) begin failures++; $display("FAIL underrun_flag got=%b exp=1", underrun_o); end
      checks++; if (aud_en_o !== 1'b1) begin failures++; $display("FAIL underrun_aud_en got=%b exp=1", aud_en_o); end
      checks++; if (frame_start_o !== 1'b1) begin failures++; $display("FAIL underrun_pulse got=%b exp=1", frame_start_o); end
      $display("underrun: data=%h underrun=%b", data_o, underrun_o);
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      checks++; if (underrun_o !== 1'b0) begin failures++; $display("FAIL underrun_clr got=%b exp=0", underrun_o); end
      $display("underrun_clr: underrun=%b", underrun_o);
   endtask

   // Frame counter is 1 on entry (clear cycle after the underrun boundary).
   task automatic test_push_at_pop();
      s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_data = 8'h31 + 8'(i);
         tick();
      end
      s_valid = 1'b0;
      checks++; if (level_o !== 7'd4) begin failures++; $display("FAIL pap_level_before got=%0d exp=4", level_o); end
      repeat (1018) tick();
      checks++; if (frame_start_o !== 1'b0) begin failures++; $display("FAIL pap_no_early_pulse got=%b exp=0", frame_start_o); end
      s_valid = 1'b1;
      s_data  = 8'h35;
      tick();
      s_valid = 1'b0;
      checks++; if (frame_start_o !== 1'b1) begin failures++; $display("FAIL pap_pulse got=%b exp=1", frame_start_o); end
      checks++; if (level_o !== 7'd1) begin failures++; $display("FAIL pap_level got=%0d exp=1", level_o); end
      checks++; if (data_o !== 32'h31323334) begin failures++; $display("FAIL pap_word got=%h exp=31323334", data_o); end
      $display("push_at_pop: data=%h level=%0d", data_o, level_o);
   endtask

   task automatic test_enable_drop();
      s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_data = 8'h36 + 8'(i);
         tick();
      end
      s_valid = 1'b0;
      repeat (496) tick();
      enable = 1'b0;
      tick();
      checks++; if (aud_en_o !== 1'b0) begin failures++; $display("FAIL drop_aud_en got=%b exp=0", aud_en_o); end
      checks++; if (data_o !== 32'h80808080) begin failures++; $display("FAIL drop_data got=%h exp=80808080", data_o); end
      checks++; if (level_o !== 7'd4) begin failures++; $display("FAIL drop_level got=%0d exp=4", level_o); end
      $display("enable_drop: aud_en=%b data=%h level=%0d", aud_en_o, data_o, level_o);
      s_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         s_data = 8'h39 + 8'(i);
         tick();
      end
      s_valid = 1'b0;
      tick();
      checks++; if (aud_en_o !== 1'b0 || level_o !== 7'd16) begin failures++; $display("FAIL idle_hold got aud_en=%b level=%0d exp aud_en=0 level=16", aud_en_o, level_o); end
      enable = 1'b1;
      tick();
      checks++; if (aud_en_o !== 1'b1) begin failures++; $display("FAIL restart_aud_en got=%b exp=1", aud_en_o); end
      checks++; if (data_o !== 32'h35363738) begin failures++; $display("FAIL restart_word got=%h exp=35363738", data_o); end
      checks++; if (level_o !== 7'd12) begin failures++; $display("FAIL restart_level got=%0d exp=12", level_o); end
      $display("restart: data=%h level=%0d", data_o, level_o);
      enable = 1'b0;
      tick();
   endtask

   task automatic test_full_wrap();
      logic [31:0] exp_word;
      logic [7:0]  b;
      int          cyc;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      enable  = 1'b0;
      acc     = 0;
      s_data  = 8'h00;
      s_valid = 1'b1;
      repeat (70) stream_tick();
      checks++; if (acc != 64) begin failures++; $display("FAIL full_accepted got=%0d exp=64", acc); end
      checks++; if (level_o !== 7'd64) begin failures++; $display("FAIL full_level got=%0d exp=64", level_o); end
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL full_s_ready got=%b exp=0", s_ready); end
      $display("full: accepted=%0d level=%0d s_ready=%b", acc, level_o, s_ready);
      enable = 1'b1;
      for (int w = 0; w < 50; w++) begin
         cyc = 0;
         while (frame_start_o !== 1'b1 && cyc < 1100) begin
            stream_tick();
            cyc++;
         end
         checks++;
         if (frame_start_o !== 1'b1) begin
            failures++;
            $display("FAIL wrap_timeout word=%0d got no frame_start exp pulse within 1100 cycles", w);
            break;
         end
         for (int j = 0; j < 4; j++) begin
            b = 8'(4 * w + j);
            exp_word[(3-j)*8 +: 8] = b;
         end
         checks++; if (data_o !== exp_word) begin failures++; $display("FAIL wrap_word_%0d got=%h exp=%h", w, data_o, exp_word); end
         checks++; if (level_o !== 7'd60) begin failures++; $display("FAIL wrap_level_%0d got=%0d exp=60", w, level_o); end
         $display("wrap word %0d: data=%h level=%0d", w, data_o, level_o);
         stream_tick();
      end
      s_valid = 1'b0;
      enable  = 1'b0;
   endtask

   initial begin
      test_reset();
      test_playback();
      test_push_at_pop();
      test_enable_drop();
      test_full_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sound_feeder

// File: doc/sound_feeder.md
Name: sound_feeder

Overview:
- Upstream stage of the 4-sample PWM audio player.
- Accepts 8-bit audio samples over a valid/ready stream and buffers them in a byte FIFO.
- Packs samples four at a time into the player's 32-bit sample word and drives the player's audio enable.
- Word updates are aligned to the player's 1024-cycle frame (4 slots × 256 PWM cycles), so the player's free-running counter stays phase-locked.

Parameters:
- DEPTH, 64, FIFO depth in bytes; power of 2, minimum 8.
- PREFILL, 16, bytes required in the FIFO before playback starts; 4 ≤ PREFILL ≤ DEPTH, multiple of 4.
- FRAME_CYCLES, 1024, clocks per packed word; must equal the player's counter period.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  playback request.
- s_valid  in  1  sample valid.
- s_ready  out  1  FIFO can accept a sample.
- s_data  in  8  unsigned sample, 0x80 = silence.
- underrun_clr  in  1  clears underrun_o.
- data_o  out  32  packed word to player; [31:24] plays first, [7:0] plays last.
- aud_en_o  out  1  player enable.
- frame_start_o  out  1  one-cycle pulse on each data_o load.
- underrun_o  out  1  sticky: a frame boundary found fewer than 4 bytes.
- level_o  out  $clog2(DEPTH)+1  FIFO byte count.

Behaviour:
- Single clock domain. rst is synchronous, active-high.
- Reset values: data_o = 32'h80808080, aud_en_o = 0, frame_start_o = 0, underrun_o = 0, level_o = 0, FIFO empty, frame_cnt = 0, state = IDLE.
- Push: a byte is accepted when s_valid && s_ready. s_ready = (level < DEPTH), combinational from the registered count.
- Pop: always 4 bytes at once, in FIFO order. Eligibility uses the count before that cycle's push; a byte pushed this cycle is never popped in the same cycle.
- Simultaneous push and pop: count becomes count + 1 − 4.
- IDLE state:
  - aud_en_o = 0, frame_cnt held at 0.
  - If enable && level ≥ PREFILL: pop 4 bytes, load data_o, assert aud_en_o, pulse frame_start_o, go to PLAY.
- PLAY state:
  - frame_cnt increments every cycle.
  - At frame_cnt == FRAME_CYCLES−1: frame_cnt wraps to 0 and frame_start_o pulses.
    - If level ≥ 4: pop 4 bytes and load data_o.
    - Otherwise: load data_o = 32'h80808080, set underrun_o, pop nothing.
  - aud_en_o stays 1 through underruns to preserve alignment.
  - If enable = 0 in PLAY: next cycle aud_en_o = 0, frame_cnt = 0, data_o = 32'h80808080, state = IDLE. FIFO contents are retained. Playback restarts only once PREFILL is met again.
- Alignment: aud_en_o rises on the same edge that loads data_o. The player's counter is 0 at that point, and both counters advance in lockstep.
- underrun_o: set has priority over a simultaneous underrun_clr. A clear with no set drops it the next cycle.
- rst mid-frame: all state returns to reset values on that edge. Buffered bytes are discarded.
- Widths: frame_cnt is $clog2(FRAME_CYCLES) bits. FIFO pointers are $clog2(DEPTH) bits and wrap naturally.

Optional Feature:
- Macro SOUND_FEEDER_REPEAT_EN.
- Defined: an underrun at a boundary reloads the previous data_o word instead of midscale. underrun_o is still set.
- Undefined: an underrun loads 32'h80808080.

Decomposition:
- Package sound_pkg holds:
  - SAMPLE_W = 8
  - SLOTS = 4
  - FRAME_CYCLES_DEF = 1024
  - MIDSCALE_WORD = 32'h80808080
  - typedef enum {IDLE, PLAY} feeder_state_t
- Sub-module sound_byte_fifo:
  - single push port and 4-byte pop port.
  - exposes count.

Test Plan:
- Reset then push 0x01..0x10 with enable=1 → aud_en_o rises the cycle after the 16th push. data_o = 0x01020304, then 0x05060708 exactly 1024 cycles later, then 0x090A0B0C.
- Push only 8 bytes, PREFILL=8, enable=1 → 2 words play, then data_o = 0x80808080, underrun_o = 1, aud_en_o stays 1. Pulse underrun_clr → underrun_o = 0.
- Push at full rate with s_valid held → s_ready falls at level 64. Exactly 64 bytes are accepted, no loss or duplication across pointer wrap over 200 bytes.
- Push coincident with a boundary pop at level 4 → level_o goes 4 → 1. The pushed byte is not in the popped word.
- Drop enable mid-frame (cycle 500) → aud_en_o = 0 next cycle, data_o = 0x80808080, level_o unchanged. Re-enable restarts at the next 4 bytes.
- With SOUND_FEEDER_REPEAT_EN defined, force an underrun after word 0xA1A2A3A4 → data_o reloads 0xA1A2A3A4 and underrun_o = 1.
